// File: rtl/relay_seq_pkg.sv
// Purpose : shared phase indices, cycle-length codes and FSM states for the relay phase sequencer.
// Latency : n/a (package: constants, types and one pure decode function).
// Backpressure : n/a.
package relay_seq_pkg;

  // Phase indices. P is not a phase, so Q..T sit directly after O.
  localparam logic [4:0] PH_A = 5'd0;
  localparam logic [4:0] PH_B = 5'd1;
  localparam logic [4:0] PH_C = 5'd2;
  localparam logic [4:0] PH_D = 5'd3;
  localparam logic [4:0] PH_E = 5'd4;
  localparam logic [4:0] PH_F = 5'd5;
  localparam logic [4:0] PH_G = 5'd6;
  localparam logic [4:0] PH_H = 5'd7;
  localparam logic [4:0] PH_I = 5'd8;
  localparam logic [4:0] PH_J = 5'd9;
  localparam logic [4:0] PH_K = 5'd10;
  localparam logic [4:0] PH_L = 5'd11;
  localparam logic [4:0] PH_M = 5'd12;
  localparam logic [4:0] PH_N = 5'd13;
  localparam logic [4:0] PH_O = 5'd14;
  localparam logic [4:0] PH_Q = 5'd15;
  localparam logic [4:0] PH_R = 5'd16;
  localparam logic [4:0] PH_S = 5'd17;
  localparam logic [4:0] PH_T = 5'd18;

  // Terminal index used until the length code is known (fetch-only, 8 phases).
  localparam logic [4:0] TERM_DEFAULT = PH_H;

  // Cycle-length codes supplied by the control decoder.
  typedef enum logic [2:0] {
    CL_8  = 3'd0,
    CL_10 = 3'd1,
    CL_12 = 3'd2,
    CL_14 = 3'd3,
    CL_19 = 3'd4
  } cyc_len_e;

  typedef struct packed {
    logic [4:0] term;  // index of the last phase of the instruction
    logic       err;   // code was not a legal length
  } term_t;

  // Map a length code to the index of the instruction's last phase.
  // Illegal codes fall back to the fetch-only length and flag an error.
  function automatic term_t len_to_term(input logic [2:0] code);
    term_t r;
    r.err  = 1'b0;
    r.term = TERM_DEFAULT;
    case (cyc_len_e'(code))
      CL_8:    r.term = PH_H;
      CL_10:   r.term = PH_J;
      CL_12:   r.term = PH_L;
      CL_14:   r.term = PH_N;
      CL_19:   r.term = PH_T;
      default: begin
        r.term = TERM_DEFAULT;
        r.err  = 1'b1;
      end
    endcase
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/relay_phase_sequencer_dwell.sv
// Purpose : 8-bit dwell counter 0..DWELL_CYCLES-1 with enable/clear; tc marks the last clock of a phase.
// Latency : tc is combinational from the count, asserted in the final dwell clock.
// Backpressure : none; clr has priority over en, and the count holds while en is low.
//
// Ports: clk, rst_n (async active-low), en (count), clr (force zero), tc (terminal-count strobe).
module relay_dwell_timer #(
  parameter int DWELL_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [7:0] LAST = 8'(DWELL_CYCLES - 1);

  logic [7:0] count;

  assign tc = en && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= (count == LAST) ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/relay_phase_sequencer.sv
// Purpose : sequences one-hot relay phases A..T with run/step/halt control and decoder-selected length.
// Latency : phase A one clock after a start request; each phase lasts DWELL_CYCLES clocks.
// Backpressure : none; halt_req defers stop to the instruction boundary, never truncating an instruction.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               level: free-run instructions
//   step              rising edge: execute one instruction
//   halt_req          stop at the next instruction boundary
//   cyc_len[2:0]      length code, sampled on the exit from FETCH_LAST
//   phase[18:0]       one-hot phase (bit15 = Q, P is skipped)
//   phase_idx[4:0]    binary index of the active phase
//   phase_adv         first clock of each new phase
//   instr_done        last clock of the last phase of an instruction
//   halted            high while idle
//   len_err           sticky illegal length code seen
module relay_phase_sequencer
  import relay_seq_pkg::*;
#(
  parameter int NUM_PHASES   = 19,
  parameter int DWELL_CYCLES = 4,
  parameter int FETCH_LAST   = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  step,
  input  logic                  halt_req,
  input  logic [2:0]            cyc_len,
  output logic [NUM_PHASES-1:0] phase,
  output logic [4:0]            phase_idx,
  output logic                  phase_adv,
  output logic                  instr_done,
  output logic                  halted,
  output logic                  len_err
);

  localparam logic [4:0] FETCH_IDX = 5'(FETCH_LAST);
  localparam logic [NUM_PHASES-1:0] ONE = {{(NUM_PHASES-1){1'b0}}, 1'b1};

  seq_state_e state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] term_q, term_d;
  logic       adv_q, adv_d;
  logic       halt_pend_q, halt_pend_d;
  logic       len_err_q, len_err_d;
  logic       step_q;

  logic       active;
  logic       tc;
  logic       step_rise;
  logic       at_fetch_last;
  logic [4:0] eff_term;
  logic       last_phase;
  term_t      lt;

  assign active    = (state_q != ST_IDLE);
  assign step_rise = step && !step_q;

  relay_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (active),
    .clr  (!active),
    .tc   (tc)
  );

  // The length is decided in the same clock that leaves FETCH_LAST, so the
  // terminal compare there must use the freshly decoded value: an 8-phase
  // instruction ends on that very advance.
  assign lt            = len_to_term(cyc_len);
  assign at_fetch_last = (idx_q == FETCH_IDX);
  assign eff_term      = at_fetch_last ? lt.term : term_q;
  assign last_phase    = active && tc && (idx_q == eff_term);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    term_d      = term_q;
    adv_d       = 1'b0;
    halt_pend_d = halt_pend_q;
    len_err_d   = len_err_q;

    case (state_q)
      ST_IDLE: begin
        idx_d       = PH_A;
        term_d      = TERM_DEFAULT;
        halt_pend_d = 1'b0;
        // A halt request in the same clock blocks any start; run wins over step.
        if (!halt_req) begin
          if (run) begin
            state_d = ST_RUN;
            adv_d   = 1'b1;
          end else if (step_rise) begin
            state_d = ST_STEP;
            adv_d   = 1'b1;
          end
        end
      end

      ST_RUN, ST_STEP: begin
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (tc) begin
          if (at_fetch_last) begin
            term_d = lt.term;
            if (lt.err) begin
              len_err_d = 1'b1;
            end
          end
          if (idx_q == eff_term) begin
            // Instruction boundary: a halt raised in this last clock still counts.
            idx_d       = PH_A;
            term_d      = TERM_DEFAULT;
            halt_pend_d = 1'b0;
            if (state_q == ST_RUN && run && !halt_pend_q && !halt_req) begin
              adv_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 5'd1;
            adv_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = PH_A;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= PH_A;
      term_q      <= TERM_DEFAULT;
      adv_q       <= 1'b0;
      halt_pend_q <= 1'b0;
      len_err_q   <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      term_q      <= term_d;
      adv_q       <= adv_d;
      halt_pend_q <= halt_pend_d;
      len_err_q   <= len_err_d;
      step_q      <= step;
    end
  end

  assign phase      = active ? (ONE << idx_q) : '0;
  assign phase_idx  = idx_q;
  assign phase_adv  = adv_q;
  assign instr_done = last_phase;
  assign halted     = !active;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_relay_phase_sequencer.sv
// Purpose : randomized + directed bench for relay_phase_sequencer, scoreboarded against a timeline model.
// Latency : model predicts every clock's outputs; monitor compares on the falling edge.
// Backpressure : n/a (bench).
module tb_relay_phase_sequencer;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic [2:0]  cyc_len = 3'd0;
  logic [18:0] phase;
  logic [4:0]  phase_idx;
  logic        phase_adv;
  logic        instr_done;
  logic        halted;
  logic        len_err;

  relay_phase_sequencer #(
    .NUM_PHASES  (19),
    .DWELL_CYCLES(D),
    .FETCH_LAST  (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .cyc_len   (cyc_len),
    .phase     (phase),
    .phase_idx (phase_idx),
    .phase_adv (phase_adv),
    .instr_done(instr_done),
    .halted    (halted),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [18:0] phase;
    logic [4:0]  idx;
    logic        adv;
    logic        done;
    logic        halted;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // ---------------- reference model ----------------
  // An instruction is a timeline: it starts at clock t0, phase k occupies
  // clocks t0+k*D .. t0+k*D+D-1, and it has 'len' phases (8 until the decoder
  // code is seen at the end of phase 7).
  bit m_busy = 0, m_stepmode = 0, m_halt = 0, m_err = 0, m_step_prev = 0;
  int m_t0 = 0, m_len = 8, m_w = 0;
  int lens[5] = '{8, 10, 12, 14, 19};

  initial begin : model
    exp_t e;
    int   el, k, r, code;
    forever begin
      @(posedge clk);
      #3;
      m_w++;
      e = '0;
      if (!rst_n) begin
        m_busy = 0; m_stepmode = 0; m_halt = 0; m_err = 0; m_step_prev = 0; m_len = 8;
        e.halted = 1'b1;
      end else begin
        if (m_busy) begin
          el = m_w - m_t0;
          k  = el / D;
          r  = el % D;
          e.phase  = 19'(1) << k;
          e.idx    = 5'(k);
          e.adv    = (r == 0);
          e.halted = 1'b0;
          e.err    = m_err;
          if (halt_req) m_halt = 1;
          if (r == D - 1) begin
            if (k == 7) begin
              code = int'(cyc_len);
              if (code <= 4) m_len = lens[code];
              else begin m_len = 8; m_err = 1; end
            end
            if (k == m_len - 1) begin
              e.done = 1'b1;
              if (!m_stepmode && run && !m_halt) begin
                m_t0 = m_w + 1; m_len = 8; m_halt = 0;
              end else begin
                m_busy = 0; m_halt = 0;
              end
            end
          end
        end else begin
          e.halted = 1'b1;
          e.err    = m_err;
          if ((run || (step && !m_step_prev)) && !halt_req) begin
            m_busy = 1; m_stepmode = !run; m_t0 = m_w + 1; m_len = 8; m_halt = 0;
          end
        end
        m_step_prev = step;
      end
      sb_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    exp_t e, got;
    forever begin
      @(negedge clk);
      got = {phase, phase_idx, phase_adv, instr_done, halted, len_err};
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty t=%0t got=%h", $time, got);
      end else begin
        e = sb_q.pop_front();
        if (got !== e) begin
          n_bad++;
          $display("FAIL cycle t=%0t got phase=%h idx=%0d adv=%b done=%b halted=%b err=%b | want phase=%h idx=%0d adv=%b done=%b halted=%b err=%b",
                   $time, got.phase, got.idx, got.adv, got.done, got.halted, got.err,
                   e.phase, e.idx, e.adv, e.done, e.halted, e.err);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit r, input bit s, input bit h, input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      run = r; step = s; halt_req = h; cyc_len = c;
    end
  endtask

  task automatic wait_phase(input logic [4:0] tgt, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (phase_adv && phase_idx == tgt) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_phase timeout target=%0d last idx=%0d", tgt, phase_idx);
    end
  endtask

  task automatic wait_halted(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (halted) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_halted timeout halted=%b", halted);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin : stim
    // reset, then free-run 8-phase instructions
    drive(0, 0, 0, 3'd0, 3);
    @(posedge clk); #1; rst_n = 1'b1;
    drive(1, 0, 0, 3'd0, 40);
    drive(0, 0, 0, 3'd0, 20);

    // 19-phase instructions
    drive(1, 0, 0, 3'd4, 50);
    drive(0, 0, 0, 3'd4, 45);

    // single step of 12 phases; a second step edge mid-instruction is ignored
    drive(0, 1, 0, 3'd2, 1);
    drive(0, 0, 0, 3'd2, 4);
    drive(0, 1, 0, 3'd2, 2);
    drive(0, 0, 0, 3'd2, 30);

    // halt requested in phase C of a 14-phase run; run stays high until idle
    drive(1, 0, 0, 3'd3, 1);
    wait_phase(5'd2, 100);
    halt_req = 1'b1;
    drive(1, 0, 0, 3'd3, 1);
    wait_halted(100);
    run = 1'b0;
    drive(0, 0, 0, 3'd3, 10);

    // illegal code at the H exit, then legal instructions: len_err stays set
    drive(1, 0, 0, 3'd6, 20);
    drive(1, 0, 0, 3'd1, 30);
    drive(0, 0, 0, 3'd1, 25);

    // asynchronous reset in phase K
    drive(1, 0, 0, 3'd2, 1);
    wait_phase(5'd10, 100);
    rst_n = 1'b0;
    #1;
    chk("rst_phase",      32'(phase),      32'd0);
    chk("rst_phase_idx",  32'(phase_idx),  32'd0);
    chk("rst_phase_adv",  32'(phase_adv),  32'd0);
    chk("rst_instr_done", 32'(instr_done), 32'd0);
    chk("rst_halted",     32'(halted),     32'd1);
    chk("rst_len_err",    32'(len_err),    32'd0);
    drive(1, 0, 0, 3'd0, 2);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_phase(5'd0, 10);
    drive(1, 0, 0, 3'd0, 20);
    drive(0, 0, 0, 3'd0, 20);

    // randomized control traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 39) == 0) run = ~run;
      step     = ($urandom_range(0, 7) == 0);
      halt_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) < 8) cyc_len = 3'($urandom_range(0, 4));
      else                          cyc_len = 3'($urandom_range(5, 7));
      rst_n = ($urandom_range(0, 999) != 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 3'd0, 50);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
